// File: rtl/exec_stage_mdu.sv
// Execute stage: single-cycle ALU, branch and jump resolution, plus an optional
// radix-2 iterative multiply/divide unit that interlocks the upstream stages.
//
// state  | meaning
// S_IDLE | no MULDIV in flight; new instructions may be accepted
// S_RUN  | one multiply/divide step per cycle, cnt counts down from XLEN-1
// S_DONE | result ready; written to the output register on the first unstalled cycle
module exec_stage_mdu #(
    parameter int XLEN   = 64,
    parameter int MDU_EN = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [2:0]      i_op,
    input  logic [2:0]      i_funct3,
    input  logic            i_funct7_5,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_rs1_value,
    input  logic [XLEN-1:0] i_rs2_value,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic            i_mem_to_reg,
    input  logic            i_reg_write,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_alu_result,
    output logic [XLEN-1:0] o_rs2_value,
    output logic            o_branch_taken,
    output logic [XLEN-1:0] o_jmp_addr,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic            o_mem_to_reg,
    output logic            o_reg_write
);
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_ALU_R  = 3'b010;
    localparam logic [2:0] OP_ALU_I  = 3'b011;
    localparam logic [2:0] OP_JAL    = 3'b100;
    localparam logic [2:0] OP_JALR   = 3'b101;
    localparam logic [2:0] OP_MULDIV = 3'b110;
    localparam int         CW        = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mdu_state_t;

    mdu_state_t        state;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   acc_hi, acc_lo, mcand, op_a, md_rs2;
    logic [2:0]        md_f3;
    logic [3:0]        md_ctl;
    logic              neg_q, neg_r, b_zero;

    logic              accept, mdu_start, mdu_write;
    logic [XLEN-1:0]   opb, alu_res, res_nx, jmp_nx, rs1_imm;
    logic [5:0]        shamt;
    logic              taken_nx, br_eq, br_lt, br_ltu, slt_ab, sltu_ab;
    logic              sgn_a, sgn_b, a_neg, b_neg;

    assign accept    = i_valid && !o_busy && !i_stall && !i_flush && (state == S_IDLE);
    assign mdu_start = accept && (i_op == OP_MULDIV) && (MDU_EN != 0);
    assign mdu_write = (state == S_DONE) && !i_stall && !i_flush;

    // ---------------- single-cycle datapath ----------------
    always_comb begin
        opb      = ((i_op == OP_ALU_R) || (i_op == OP_BRANCH) || (i_op == OP_JAL) ||
                    (i_op == OP_JALR) || (i_op == OP_MULDIV)) ? i_rs2_value : i_imm;
        shamt    = (XLEN == 64) ? opb[5:0] : {1'b0, opb[4:0]};
        slt_ab   = $signed(i_rs1_value) < $signed(opb);
        sltu_ab  = i_rs1_value < opb;
        br_eq    = i_rs1_value == i_rs2_value;
        br_lt    = $signed(i_rs1_value) < $signed(i_rs2_value);
        br_ltu   = i_rs1_value < i_rs2_value;
        rs1_imm  = i_rs1_value + i_imm;

        alu_res = '0;
        case (i_funct3)
            3'b000: alu_res = ((i_op == OP_ALU_R) && i_funct7_5) ? i_rs1_value - opb
                                                                 : i_rs1_value + opb;
            3'b001: alu_res = i_rs1_value << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, slt_ab};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, sltu_ab};
            3'b100: alu_res = i_rs1_value ^ opb;
            3'b101: alu_res = i_funct7_5 ? XLEN'($signed(i_rs1_value) >>> shamt)
                                         : i_rs1_value >> shamt;
            3'b110: alu_res = i_rs1_value | opb;
            default: alu_res = i_rs1_value & opb;
        endcase

        taken_nx = 1'b0;
        jmp_nx   = i_pc + i_imm;
        case (i_op)
            OP_ALU_R, OP_ALU_I: res_nx = alu_res;
            OP_BRANCH: begin
                res_nx = '0;
                case (i_funct3)
                    3'b000:  taken_nx = br_eq;
                    3'b001:  taken_nx = !br_eq;
                    3'b100:  taken_nx = br_lt;
                    3'b101:  taken_nx = !br_lt;
                    3'b110:  taken_nx = br_ltu;
                    3'b111:  taken_nx = !br_ltu;
                    default: taken_nx = 1'b0;
                endcase
            end
            OP_JAL: begin
                res_nx   = i_pc + XLEN'(4);
                taken_nx = 1'b1;
            end
            OP_JALR: begin
                res_nx   = i_pc + XLEN'(4);
                taken_nx = 1'b1;
                jmp_nx   = {rs1_imm[XLEN-1:1], 1'b0};
            end
            OP_MULDIV: res_nx = '0;
            default:   res_nx = rs1_imm;
        endcase
    end

    // ---------------- multiply/divide step and result ----------------
    logic [XLEN:0]     mul_sum, div_sh;
    logic [XLEN-1:0]   div_rem, step_hi, step_lo, quo, rem, mdu_res;
    logic [2*XLEN-1:0] prod, prod_f;
    logic              div_ge;

    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        div_sh  = {acc_hi, acc_lo[XLEN-1]};
        div_ge  = div_sh >= {1'b0, mcand};
        div_rem = div_sh[XLEN-1:0] - mcand;
        if (md_f3[2]) begin
            step_hi = div_ge ? div_rem : div_sh[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end

        prod   = {acc_hi, acc_lo};
        prod_f = neg_q ? -prod : prod;
        quo    = neg_q ? -acc_lo : acc_lo;
        rem    = neg_r ? -acc_hi : acc_hi;
        case (md_f3)
            3'b000:         mdu_res = prod_f[XLEN-1:0];
            3'b100, 3'b101: mdu_res = b_zero ? '1 : quo;
            3'b110, 3'b111: mdu_res = b_zero ? op_a : rem;
            default:        mdu_res = prod_f[2*XLEN-1:XLEN];
        endcase

        // Magnitudes are used internally; MULHSU treats only rs1 as signed.
        sgn_a = (i_funct3 != 3'b011) && (i_funct3 != 3'b101) && (i_funct3 != 3'b111);
        sgn_b = sgn_a && (i_funct3 != 3'b010);
        a_neg = sgn_a && i_rs1_value[XLEN-1];
        b_neg = sgn_b && i_rs2_value[XLEN-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mcand  <= '0;
            op_a   <= '0;
            md_rs2 <= '0;
            md_f3  <= '0;
            md_ctl <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
        end else if (i_flush) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_busy <= 1'b0;
                    if (mdu_start) begin
                        state  <= S_RUN;
                        cnt    <= CW'(XLEN-1);
                        acc_hi <= '0;
                        acc_lo <= a_neg ? -i_rs1_value : i_rs1_value;
                        mcand  <= b_neg ? -i_rs2_value : i_rs2_value;
                        op_a   <= i_rs1_value;
                        md_rs2 <= i_rs2_value;
                        md_f3  <= i_funct3;
                        md_ctl <= {i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write};
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        b_zero <= (i_rs2_value == '0);
                    end
                end
                S_RUN: begin
                    o_busy <= 1'b1;
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    if (cnt == '0) state <= S_DONE;
                    else           cnt   <= cnt - 1'b1;
                end
                S_DONE: begin
                    if (!i_stall) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid        <= 1'b0;
            o_alu_result   <= '0;
            o_rs2_value    <= '0;
            o_branch_taken <= 1'b0;
            o_jmp_addr     <= '0;
            o_mem_read     <= 1'b0;
            o_mem_write    <= 1'b0;
            o_mem_to_reg   <= 1'b0;
            o_reg_write    <= 1'b0;
        end else if (i_flush) begin
            o_valid        <= 1'b0;
            o_branch_taken <= 1'b0;
            o_mem_read     <= 1'b0;
            o_mem_write    <= 1'b0;
            o_mem_to_reg   <= 1'b0;
            o_reg_write    <= 1'b0;
        end else if (i_stall) begin
            o_valid <= o_valid;
        end else if (mdu_write) begin
            o_valid        <= 1'b1;
            o_alu_result   <= mdu_res;
            o_rs2_value    <= md_rs2;
            o_branch_taken <= 1'b0;
            {o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write} <= md_ctl;
        end else if (accept && !mdu_start) begin
            o_valid        <= 1'b1;
            o_alu_result   <= res_nx;
            o_rs2_value    <= i_rs2_value;
            o_branch_taken <= taken_nx;
            o_jmp_addr     <= jmp_nx;
            o_mem_read     <= i_mem_read;
            o_mem_write    <= i_mem_write;
            o_mem_to_reg   <= i_mem_to_reg;
            o_reg_write    <= i_reg_write;
        end else begin
            // bubble: data outputs keep their last value
            o_valid        <= 1'b0;
            o_branch_taken <= 1'b0;
            o_mem_read     <= 1'b0;
            o_mem_write    <= 1'b0;
            o_mem_to_reg   <= 1'b0;
            o_reg_write    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_exec_stage_mdu.sv
// Directed bench for exec_stage_mdu: a vector table for single-cycle ops and
// the MDU, plus hand-written reset/stall/flush sequences and an XLEN=32 instance.
module tb_exec_stage_mdu;
    localparam logic [63:0] M1  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

    logic        clk, rst_n, valid, stall, flush, f75, mr, mw, mtr, rw;
    logic [2:0]  op, f3;
    logic [63:0] pc, imm, rs1, rs2;
    logic        busy, ov, taken, omr, omw, omtr, orw;
    logic [63:0] res, rs2o, jmp;

    logic        v32, f75_32;
    logic [2:0]  op32, f3_32;
    logic [31:0] pc32, imm32, rs1_32, rs2_32;
    logic        busy32, ov32, taken32, omr32, omw32, omtr32, orw32;
    logic [31:0] res32, rs2o32, jmp32;

    int checks = 0;
    int errors = 0;

    exec_stage_mdu #(.XLEN(64), .MDU_EN(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_op(op), .i_funct3(f3), .i_funct7_5(f75), .i_pc(pc), .i_imm(imm),
        .i_rs1_value(rs1), .i_rs2_value(rs2), .i_mem_read(mr), .i_mem_write(mw),
        .i_mem_to_reg(mtr), .i_reg_write(rw), .o_busy(busy), .o_valid(ov),
        .o_alu_result(res), .o_rs2_value(rs2o), .o_branch_taken(taken), .o_jmp_addr(jmp),
        .o_mem_read(omr), .o_mem_write(omw), .o_mem_to_reg(omtr), .o_reg_write(orw));

    exec_stage_mdu #(.XLEN(32), .MDU_EN(1)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v32), .i_stall(stall), .i_flush(flush),
        .i_op(op32), .i_funct3(f3_32), .i_funct7_5(f75_32), .i_pc(pc32), .i_imm(imm32),
        .i_rs1_value(rs1_32), .i_rs2_value(rs2_32), .i_mem_read(mr), .i_mem_write(mw),
        .i_mem_to_reg(mtr), .i_reg_write(rw), .o_busy(busy32), .o_valid(ov32),
        .o_alu_result(res32), .o_rs2_value(rs2o32), .o_branch_taken(taken32), .o_jmp_addr(jmp32),
        .o_mem_read(omr32), .o_mem_write(omw32), .o_mem_to_reg(omtr32), .o_reg_write(orw32));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  f3;
        logic        f75;
        logic [63:0] pc, imm, rs1, rs2, res;
        logic        taken;
        logic [63:0] jmp;
        logic        cj;
        logic [3:0]  ctl;
    } vec_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [63:0] a, b, exp;
    } md_t;

    localparam int NV = 22;
    localparam int NM = 14;
    vec_t tab[NV];
    md_t  mtab[NM];

    function automatic vec_t v(input logic [2:0] o, f, input logic s7,
                               input logic [63:0] p, im, a, b, r, input logic tk,
                               input logic [63:0] j, input logic cj, input logic [3:0] c);
        vec_t t;
        t.op = o; t.f3 = f; t.f75 = s7; t.pc = p; t.imm = im; t.rs1 = a; t.rs2 = b;
        t.res = r; t.taken = tk; t.jmp = j; t.cj = cj; t.ctl = c;
        return t;
    endfunction

    function automatic md_t m(input logic [2:0] f, input logic [63:0] a, b, e);
        md_t t;
        t.f3 = f; t.a = a; t.b = b; t.exp = e;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, f, input logic s7,
                         input logic [63:0] p, im, a, b, input logic [3:0] c);
        op = o; f3 = f; f75 = s7; pc = p; imm = im; rs1 = a; rs2 = b;
        {mr, mw, mtr, rw} = c;
        valid = 1'b1;
    endtask

    // Start at a negedge; returns at the negedge where o_valid is seen.
    task automatic run_mdu64(input string nm, input logic [2:0] f, input logic [63:0] a, b, exp);
        int lat, nb;
        drive(3'b110, f, 1'b0, 64'h0, 64'h0, a, b, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        lat = 0;
        nb  = busy ? 1 : 0;
        while (!ov && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy) nb++;
        end
        chk({nm, " latency"}, 64'(lat), 64'd65);
        chk({nm, " busy cycles"}, 64'(nb), 64'd64);
        chk({nm, " result"}, res, exp);
        chk({nm, " ctl"}, {60'b0, omr, omw, omtr, orw}, 64'd1);
    endtask

    task automatic run_mdu32(input string nm, input logic [2:0] f, input logic [31:0] a, b, exp);
        int lat, nb;
        op32 = 3'b110; f3_32 = f; f75_32 = 1'b0; rs1_32 = a; rs2_32 = b;
        {mr, mw, mtr, rw} = 4'b0001;
        v32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v32 = 1'b0;
        lat = 0;
        nb  = busy32 ? 1 : 0;
        while (!ov32 && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy32) nb++;
        end
        chk({nm, " latency"}, 64'(lat), 64'd33);
        chk({nm, " busy cycles"}, 64'(nb), 64'd32);
        chk({nm, " result"}, {32'b0, res32}, {32'b0, exp});
    endtask

    initial begin
        int nv;
        rst_n = 1'b0; valid = 1'b0; stall = 1'b0; flush = 1'b0;
        op = '0; f3 = '0; f75 = 1'b0; pc = '0; imm = '0; rs1 = '0; rs2 = '0;
        mr = 1'b0; mw = 1'b0; mtr = 1'b0; rw = 1'b0;
        v32 = 1'b0; op32 = '0; f3_32 = '0; f75_32 = 1'b0;
        pc32 = '0; imm32 = '0; rs1_32 = '0; rs2_32 = '0;

        //             op     f3     f75  pc          imm        rs1        rs2        res        tk    jmp        cj    ctl
        tab[0]  = v(3'd2, 3'd0, 1'b0, 64'h0,     64'h0,     64'd5,     64'd7,     64'd12,    1'b0, 64'h0,     1'b0, 4'b0001);
        tab[1]  = v(3'd2, 3'd0, 1'b1, 64'h0,     64'h0,     64'd3,     64'd5,     M1 - 64'd1, 1'b0, 64'h0,    1'b0, 4'b0001);
        tab[2]  = v(3'd2, 3'd5, 1'b1, 64'h0,     64'h0,     MIN,       64'd63,    M1,        1'b0, 64'h0,     1'b0, 4'b0001);
        tab[3]  = v(3'd2, 3'd5, 1'b0, 64'h0,     64'h0,     MIN,       64'd63,    64'd1,     1'b0, 64'h0,     1'b0, 4'b0001);
        tab[4]  = v(3'd2, 3'd3, 1'b0, 64'h0,     64'h0,     64'd1,     M1,        64'd1,     1'b0, 64'h0,     1'b0, 4'b0001);
        tab[5]  = v(3'd2, 3'd2, 1'b0, 64'h0,     64'h0,     M1,        64'd1,     64'd1,     1'b0, 64'h0,     1'b0, 4'b0001);
        tab[6]  = v(3'd2, 3'd1, 1'b0, 64'h0,     64'h0,     64'd1,     64'd67,    64'd8,     1'b0, 64'h0,     1'b0, 4'b0001);
        tab[7]  = v(3'd3, 3'd0, 1'b1, 64'h0,     64'd3,     64'd10,    64'd100,   64'd13,    1'b0, 64'h0,     1'b0, 4'b0001);
        tab[8]  = v(3'd3, 3'd4, 1'b0, 64'h0,     64'hFF,    64'hF0,    64'h0,     64'h0F,    1'b0, 64'h0,     1'b0, 4'b0001);
        tab[9]  = v(3'd2, 3'd6, 1'b0, 64'h0,     64'h0,     64'hF0,    64'h0F,    64'hFF,    1'b0, 64'h0,     1'b0, 4'b0001);
        tab[10] = v(3'd2, 3'd7, 1'b0, 64'h0,     64'h0,     64'hF0,    64'h3C,    64'h30,    1'b0, 64'h0,     1'b0, 4'b0001);
        tab[11] = v(3'd0, 3'd3, 1'b0, 64'h0,     M1 - 64'd3, 64'h1000, 64'h0,     64'hFFC,   1'b0, 64'h0,     1'b0, 4'b1011);
        tab[12] = v(3'd7, 3'd3, 1'b0, 64'h0,     64'h20,    64'h10,    64'hDEAD,  64'h30,    1'b0, 64'h0,     1'b0, 4'b0100);
        tab[13] = v(3'd1, 3'd4, 1'b0, 64'h100,   M1 - 64'd7, M1,       64'd1,     64'h0,     1'b1, 64'hF8,    1'b1, 4'b0000);
        tab[14] = v(3'd1, 3'd6, 1'b0, 64'h100,   M1 - 64'd7, M1,       64'd1,     64'h0,     1'b0, 64'hF8,    1'b1, 4'b0000);
        tab[15] = v(3'd1, 3'd0, 1'b0, 64'h200,   64'h10,    64'd9,     64'd9,     64'h0,     1'b1, 64'h210,   1'b1, 4'b0000);
        tab[16] = v(3'd1, 3'd1, 1'b0, 64'h200,   64'h10,    64'd9,     64'd9,     64'h0,     1'b0, 64'h210,   1'b1, 4'b0000);
        tab[17] = v(3'd1, 3'd5, 1'b0, 64'h200,   64'h10,    M1,        64'd1,     64'h0,     1'b0, 64'h210,   1'b1, 4'b0000);
        tab[18] = v(3'd1, 3'd7, 1'b0, 64'h200,   64'h10,    M1,        64'd1,     64'h0,     1'b1, 64'h210,   1'b1, 4'b0000);
        tab[19] = v(3'd1, 3'd2, 1'b0, 64'h200,   64'h10,    64'd9,     64'd9,     64'h0,     1'b0, 64'h210,   1'b1, 4'b0000);
        tab[20] = v(3'd4, 3'd0, 1'b0, 64'h1000,  64'h20,    64'h0,     64'h0,     64'h1004,  1'b1, 64'h1020,  1'b1, 4'b0001);
        tab[21] = v(3'd5, 3'd0, 1'b0, 64'h400,   64'h0,     64'h203,   64'h0,     64'h404,   1'b1, 64'h202,   1'b1, 4'b0001);

        mtab[0]  = m(3'd0, 64'd7,   M1 - 64'd2,  M1 - 64'd20);
        mtab[1]  = m(3'd3, M1,      M1,          M1 - 64'd1);
        mtab[2]  = m(3'd1, M1,      M1,          64'd0);
        mtab[3]  = m(3'd2, M1,      64'd2,       M1);
        mtab[4]  = m(3'd1, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1);
        mtab[5]  = m(3'd4, 64'd100, 64'd0,       M1);
        mtab[6]  = m(3'd6, M1 - 64'd6, 64'd0,    M1 - 64'd6);
        mtab[7]  = m(3'd5, 64'd5,   64'd0,       M1);
        mtab[8]  = m(3'd4, MIN,     M1,          MIN);
        mtab[9]  = m(3'd6, MIN,     M1,          64'd0);
        mtab[10] = m(3'd4, M1 - 64'd6, 64'd2,    M1 - 64'd2);
        mtab[11] = m(3'd6, M1 - 64'd6, 64'd2,    M1);
        mtab[12] = m(3'd5, 64'd100, 64'd7,       64'd14);
        mtab[13] = m(3'd7, 64'd100, 64'd7,       64'd2);

        @(posedge clk);
        @(negedge clk);
        chk("reset valid", {63'b0, ov}, 64'd0);
        chk("reset busy", {63'b0, busy}, 64'd0);
        chk("reset result", res, 64'd0);
        chk("reset ctl", {59'b0, taken, omr, omw, omtr, orw}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(tab[i].op, tab[i].f3, tab[i].f75, tab[i].pc, tab[i].imm,
                  tab[i].rs1, tab[i].rs2, tab[i].ctl);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d valid", i), {63'b0, ov}, 64'd1);
            chk($sformatf("v%0d result", i), res, tab[i].res);
            chk($sformatf("v%0d rs2", i), rs2o, tab[i].rs2);
            chk($sformatf("v%0d taken", i), {63'b0, taken}, {63'b0, tab[i].taken});
            chk($sformatf("v%0d ctl", i), {60'b0, omr, omw, omtr, orw}, {60'b0, tab[i].ctl});
            if (tab[i].cj) chk($sformatf("v%0d target", i), jmp, tab[i].jmp);
        end
        valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bubble valid", {63'b0, ov}, 64'd0);
        chk("bubble taken", {63'b0, taken}, 64'd0);
        chk("bubble data hold", res, 64'h404);

        for (int i = 0; i < NM; i++)
            run_mdu64($sformatf("mdu%0d", i), mtab[i].f3, mtab[i].a, mtab[i].b, mtab[i].exp);

        // reset in the middle of a divide
        drive(3'b110, 3'd4, 1'b0, 64'h0, 64'h0, 64'd100, 64'd7, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", {63'b0, busy}, 64'd0);
        chk("midrst valid", {63'b0, ov}, 64'd0);
        chk("midrst result", res, 64'd0);
        chk("midrst ctl", {60'b0, omr, omw, omtr, orw}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'd2, 3'd0, 1'b0, 64'h0, 64'h0, 64'd5, 64'd7, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        chk("postrst add", res, 64'd12);
        chk("postrst valid", {63'b0, ov}, 64'd1);

        // three-cycle stall freezes a JAL result, including the redirect pulse
        drive(3'd4, 3'd0, 1'b0, 64'h1000, 64'h20, 64'h0, 64'h0, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        stall = 1'b1;
        drive(3'd2, 3'd0, 1'b0, 64'h0, 64'h0, 64'd1, 64'd1, 4'b0001);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("stall%0d result", k), res, 64'h1004);
            chk($sformatf("stall%0d taken", k), {63'b0, taken}, 64'd1);
            chk($sformatf("stall%0d valid", k), {63'b0, ov}, 64'd1);
        end
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        chk("unstall result", res, 64'd2);
        chk("unstall taken", {63'b0, taken}, 64'd0);

        // stall arriving while the MDU sits in DONE
        drive(3'b110, 3'd0, 1'b0, 64'h0, 64'h0, 64'd6, 64'd7, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (64) begin
            @(posedge clk);
            @(negedge clk);
        end
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("done stall%0d valid", k), {63'b0, ov}, 64'd0);
            chk($sformatf("done stall%0d busy", k), {63'b0, busy}, 64'd1);
        end
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("done stall write", {63'b0, ov}, 64'd1);
        chk("done stall result", res, 64'd42);
        chk("done stall busy", {63'b0, busy}, 64'd0);

        // flush during RUN
        drive(3'b110, 3'd4, 1'b0, 64'h0, 64'h0, 64'd1000, 64'd3, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", {63'b0, busy}, 64'd0);
        chk("flush valid", {63'b0, ov}, 64'd0);
        nv = 0;
        repeat (70) begin
            @(posedge clk);
            @(negedge clk);
            if (ov || busy) nv++;
        end
        chk("flush no late write", 64'(nv), 64'd0);

        // flush beats stall
        drive(3'd4, 3'd0, 1'b0, 64'h2000, 64'h40, 64'h0, 64'h0, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        stall = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        valid = 1'b0;
        chk("flush+stall valid", {63'b0, ov}, 64'd0);
        chk("flush+stall taken", {63'b0, taken}, 64'd0);
        chk("flush+stall ctl", {60'b0, omr, omw, omtr, orw}, 64'd0);
        chk("flush+stall data hold", res, 64'h2004);

        // XLEN=32 instance
        op32 = 3'd2; f3_32 = 3'd1; f75_32 = 1'b0; rs1_32 = 32'd1; rs2_32 = 32'd33;
        {mr, mw, mtr, rw} = 4'b0001;
        v32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v32 = 1'b0;
        chk("x32 sll", {32'b0, res32}, 64'd2);
        chk("x32 sll valid", {63'b0, ov32}, 64'd1);
        run_mdu32("x32 mul", 3'd0, 32'h1_0000, 32'h1_0000, 32'd0);
        run_mdu32("x32 mulhu", 3'd3, 32'h1_0000, 32'h1_0000, 32'd1);
        run_mdu32("x32 div", 3'd4, 32'd100, 32'd7, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exec_stage_mdu.md
# exec_stage_mdu

Parameterised execute stage for the in-order RISC-V pipeline, placed between decode and memory. It performs integer ALU operations, branch resolution and jump target generation in one cycle. An optional iterative multiply/divide unit (M extension) stalls the upstream stages while it runs. Results and pass-through control bits are held in a single output register with valid, stall and flush handling.

## Interface
- `XLEN`, 64: datapath width; 32 or 64.
- `MDU_EN`, 1: 1 builds the multiply/divide unit. With 0, any MULDIV op produces result 0 in one cycle.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_valid` in 1: input instruction valid.
- `i_stall` in 1: downstream stall; holds the output register.
- `i_flush` in 1: kill the in-flight and incoming instruction.
- `i_op` in 3: 000 ADDR (rs1+imm), 001 BRANCH, 010 ALU_R, 011 ALU_I, 100 JAL, 101 JALR, 110 MULDIV; 111 is treated as ADDR.
- `i_funct3` in 3, `i_funct7_5` in 1: operation select, instruction bits [14:12] and [30].
- `i_pc`, `i_imm`, `i_rs1_value`, `i_rs2_value` in XLEN: operands. `i_imm` is sign-extended and is a byte offset.
- `i_mem_read`, `i_mem_write`, `i_mem_to_reg`, `i_reg_write` in 1: pass-through control.
- `o_busy` out 1: MDU running; upstream must hold its inputs.
- `o_valid` out 1: output register holds a live instruction.
- `o_alu_result` out XLEN: result, or load/store address.
- `o_rs2_value` out XLEN: store data.
- `o_branch_taken` out 1: redirect the fetch stage; asserted for a taken branch, JAL or JALR.
- `o_jmp_addr` out XLEN: redirect target.
- `o_mem_read`, `o_mem_write`, `o_mem_to_reg`, `o_reg_write` out 1: registered pass-through control.

## Operation
- **Accept condition:** `i_valid && !o_busy && !i_stall && !i_flush`.
- **ALU ops:** ALU_R and ALU_I implement ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - SUB is selected by `i_funct7_5`, and only for ALU_R.
  - Shift amount is `b[5:0]` when XLEN=64 and `b[4:0]` when XLEN=32.
  - Operand b is `i_imm` for ALU_I and ADDR, otherwise rs2.
- **BRANCH:** funct3 selects BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
  - Target = `pc+imm`.
  - Result = 0.
  - Funct3 010 and 011 are never taken.
- **JAL:** result = `pc+4`, target = `pc+imm`, taken = 1.
- **JALR:** result = `pc+4`, target = `(rs1+imm) & ~1`, taken = 1.
- **Arithmetic:** all arithmetic is modulo 2^XLEN.
- **MULDIV, funct3 selects:** MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Operands are latched on accept, and the unit iterates one bit per cycle.
  - Division by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder = 0.
- **MDU states:**
  - IDLE → RUN on accept of a MULDIV; `o_busy` goes high in the next cycle.
  - RUN: iteration counter decrements from XLEN-1; at 0 go to DONE.
  - DONE: write the output register unless `i_stall`; then go to IDLE, with `o_busy` low in the following cycle.
  - `i_flush` in any state returns to IDLE immediately and writes nothing.
- **Stall:** while `i_stall` is high, all outputs hold their values, including `o_valid`. The MDU still iterates and waits in DONE.
- **Flush:** on the next edge `o_valid`, `o_branch_taken` and all control outputs go to 0. Data outputs hold. Flush beats stall.
- **Bubble:** a cycle with no accept and no stall loads `o_valid=0` and clears control and `o_branch_taken`.

## Timing
- **Reset:** while `i_rst_n` is low, every output and every internal register is 0 and the MDU is IDLE. Deassertion is synchronous to the first following edge.
- **Single-cycle ops:** latency 1; outputs are valid one edge after accept, and throughput is one per cycle.
- **MULDIV:** accept at edge 0, `o_busy` high from edge 1, result and `o_valid` at edge XLEN+1, `o_busy` low after edge XLEN+1. Latency is XLEN+1.
- **Interlock:** the upstream stage holds its inputs while `o_busy` is high. This block does not re-accept until it returns to IDLE.
- **Redirect:** `o_branch_taken` is a one-cycle registered pulse per taken instruction; an extended stall extends it. Flushing younger instructions is the hazard unit's job.

## Test plan
- **Reset mid-run:** assert `i_rst_n`=0 mid-DIV → all outputs 0 immediately; after release, ADD 5+7 → `o_alu_result`=12 one cycle later.
- **ALU sweep, XLEN=64:** SUB 3-5 → 0xFFFF_FFFF_FFFF_FFFE; SRA of 0x8000_0000_0000_0000 by 63 → all ones; SLTU 1<-1 → 1; ALU_I with funct7_5=1 and funct3=000 → ADD.
- **Branches:** BLT -1<1 taken, BLTU -1<1 not taken; pc=0x100, imm=-8 → `o_jmp_addr`=0xF8. JALR rs1=0x203, imm=0 → target 0x202, result pc+4.
- **MDU:**
  - MUL 7*-3 → -21 at latency 65, with `o_busy` high for 64 cycles.
  - MULHU all-ones*all-ones → 0xFFFF_FFFF_FFFF_FFFE.
  - DIV by 0 → all ones; REM by 0 → dividend.
  - DIV 0x8000_0000_0000_0000/-1 → dividend; REM → 0.
- **Stall/flush:**
  - `i_stall` for 3 cycles → outputs frozen.
  - Stall arriving during DONE → result is written one cycle after the stall drops.
  - Flush at RUN cycle 10 → no `o_valid`, `o_busy` low next cycle.
  - Flush together with stall → `o_valid`=0.
- **XLEN=32 build:** MUL 0x10000*0x10000 → 0, MULHU → 1; SLL by 33 → shift by 1; DIV latency 33.
